prefix_rr_arbiter: RTL

- Round-robin arbiter that shares one decoupled "some_prefix" channel (valid/ready plus three 8-bit data fields) among NUM_REQ requesters.
- Sits in front of the single consumer sub-block that owns the channel.
- Registers the winning beat in a one-entry output slot and tags it with the source index.
- Keeps a running count of completed output transfers.

---
 rtl/prefix_rr_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/prefix_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | prefix_rr_arbiter: round-robin arbiter onto one registered valid/ready
// | channel; tags each beat with its source and counts output handshakes.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module prefix_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        in_valid,
  output logic [NUM_REQ-1:0]        in_ready,
  input  logic [NUM_REQ*DATA_W-1:0] in_bits_data_0,
  input  logic [NUM_REQ*DATA_W-1:0] in_bits_data_1,
  input  logic [NUM_REQ*DATA_W-1:0] in_bits_data_2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_bits_data_0,
  output logic [DATA_W-1:0]         out_bits_data_1,
  output logic [DATA_W-1:0]         out_bits_data_2,
  output logic [SRC_W-1:0]          out_src,
  output logic [31:0]               xfer_count
);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] grant;
  logic [SRC_W:0]   idx;
  logic             any_valid;
  logic             slot_free;
  logic             accept;
  logic [31:0]      count;

  assign any_valid  = |in_valid;
  assign slot_free  = !out_valid || out_ready;
  assign accept     = slot_free && any_valid && !reset;
  assign xfer_count = count;

  // Scan from the farthest offset back to ptr so the nearest valid requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SRC_W + 1)'(k);
      if (idx >= (SRC_W + 1)'(NUM_REQ)) begin
        idx = idx - (SRC_W + 1)'(NUM_REQ);
      end
      if (in_valid[idx[SRC_W-1:0]]) begin
        grant = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_bits_data_0 <= '0;
      out_bits_data_1 <= '0;
      out_bits_data_2 <= '0;
      out_src         <= '0;
      ptr             <= '0;
      count           <= '0;
    end else begin
      if (out_valid && out_ready) begin
        count <= count + 32'd1;
      end
      if (accept) begin
        out_valid       <= 1'b1;
        out_bits_data_0 <= in_bits_data_0[int'(grant)*DATA_W +: DATA_W];
        out_bits_data_1 <= in_bits_data_1[int'(grant)*DATA_W +: DATA_W];
        out_bits_data_2 <= in_bits_data_2[int'(grant)*DATA_W +: DATA_W];
        out_src         <= grant;
        ptr             <= (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + SRC_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
